// File: rtl/sv_uart_tx_arb.sv
// sv_uart_tx_arb: packet-level round-robin arbiter sharing one UART TX stream between N_CH byte sources.
module sv_uart_tx_arb #(
  parameter int N_CH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int HDR_EN = 1,
  parameter logic [DATA_WIDTH-1:0] HDR_BASE = 8'hA0
) (
  input  logic                         iclk,
  input  logic                         irst,
  input  logic [N_CH*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N_CH-1:0]              s_axis_tvalid,
  input  logic [N_CH-1:0]              s_axis_tlast,
  output logic [N_CH-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  input  logic [N_CH-1:0]              iena,
  input  logic [15:0]                  igap,
  output logic [N_CH-1:0]              ogrant,
  output logic                         obusy
);
  localparam int IW = $clog2(N_CH);
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_GAP} st_t;
  st_t st_q;
  logic [IW-1:0] ptr_q, sel;
  logic [N_CH-1:0] grant_q, req;
  logic [15:0] gap_q;
  logic [DATA_WIDTH-1:0] ch_data [N_CH];
  logic [DATA_WIDTH-1:0] hdr;
  logic beat;
  int j;
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign ch_data[g] = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
  end
  assign req = s_axis_tvalid & iena;
  assign hdr = HDR_BASE + DATA_WIDTH'(ptr_q);
  assign beat = st_q == ST_DATA && s_axis_tvalid[ptr_q] && m_axis_tready;
  // Descending scan so the nearest requester after ptr_q is the last, winning, assignment.
  always_comb begin
    sel = ptr_q;
    j = 0;
    for (int k = N_CH; k >= 1; k--) begin
      j = (int'(ptr_q) + k) % N_CH;
      if (req[IW'(j)]) sel = IW'(j);
    end
  end
  always_ff @(posedge iclk) begin
    if (irst) begin
      st_q <= ST_IDLE;
      ptr_q <= IW'(N_CH - 1);
      grant_q <= '0;
      gap_q <= '0;
    end else begin
      case (st_q)
        ST_IDLE: if (|req) begin
          ptr_q <= sel;
          grant_q <= N_CH'(1) << sel;
          st_q <= HDR_EN != 0 ? ST_HDR : ST_DATA;
        end
        ST_HDR: if (m_axis_tready) st_q <= ST_DATA;
        ST_DATA: if (beat && s_axis_tlast[ptr_q]) begin
          grant_q <= '0;
          gap_q <= igap;
          st_q <= igap == 16'd0 ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          gap_q <= gap_q - 16'd1;
          if (gap_q <= 16'd1) st_q <= ST_IDLE;
        end
        default: begin
          st_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end
  assign m_axis_tdata = st_q == ST_HDR ? hdr : ch_data[ptr_q];
  assign m_axis_tvalid = st_q == ST_HDR || (st_q == ST_DATA && s_axis_tvalid[ptr_q]);
  assign s_axis_tready = (st_q == ST_DATA && m_axis_tready) ? grant_q : '0;
  assign ogrant = grant_q;
  assign obusy = st_q != ST_IDLE;
endmodule

// File: tb/tb_sv_uart_tx_arb.sv
// tb_sv_uart_tx_arb: randomized scoreboard bench for the UART TX round-robin arbiter.
module tb_sv_uart_tx_arb;
  localparam int N = 4;
  localparam int DW = 8;
  localparam logic [7:0] HB = 8'hA0;
  typedef struct { logic [7:0] data; logic last; logic first; } beat_t;
  typedef struct { int ch; logic [7:0] data; logic hdr; int idle; } exp_t;
  logic iclk = 0, irst;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0] s_axis_tvalid, s_axis_tlast, s_axis_tready, iena, ogrant;
  logic [DW-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready, obusy;
  logic [15:0] igap;
  beat_t chq [N][$];
  exp_t exq [$];
  int tests = 0, fails = 0, mode = 0, mptr = N - 1, g2 = 0, cyc = 0;
  bit mon_en = 0;
  sv_uart_tx_arb #(.N_CH(N), .DATA_WIDTH(DW), .HDR_EN(1), .HDR_BASE(HB)) dut (
    .iclk(iclk), .irst(irst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .iena(iena), .igap(igap),
    .ogrant(ogrant), .obusy(obusy));
  always #5 iclk = ~iclk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask
  task automatic push_beat(int c, logic [7:0] d, logic last, logic first);
    beat_t b;
    b.data = d; b.last = last; b.first = first;
    chq[c].push_back(b);
  endtask
  task automatic add_pkt(int c, int len);
    for (int i = 0; i < len; i++) push_beat(c, 8'($urandom), i == len - 1, i == 0);
  endtask
  // Reference: strict round robin over channels that are enabled and still hold packets.
  task automatic model();
    int pos [N];
    int f;
    bit first = 1;
    exp_t e;
    for (int c = 0; c < N; c++) pos[c] = 0;
    forever begin
      f = -1;
      for (int k = 1; k <= N; k++)
        if (f < 0 && iena[(mptr + k) % N] && pos[(mptr + k) % N] < chq[(mptr + k) % N].size()) f = (mptr + k) % N;
      if (f < 0) break;
      e.ch = f; e.data = HB + 8'(f); e.hdr = 1; e.idle = first ? -1 : int'(igap) + 1;
      exq.push_back(e);
      forever begin
        e.data = chq[f][pos[f]].data; e.hdr = 0; e.idle = -1;
        exq.push_back(e);
        pos[f]++;
        if (chq[f][pos[f] - 1].last) break;
      end
      mptr = f;
      first = 0;
    end
  endtask
  task automatic wait_done();
    int t = 0;
    while ((exq.size() != 0 || obusy) && t < 5000) begin
      @(negedge iclk);
      t++;
    end
    chk("drain_left", exq.size(), 0);
    chk("drain_busy", obusy, 0);
    for (int c = 0; c < N; c++) chq[c].delete();
    repeat (3) @(negedge iclk);
  endtask
  initial begin
    logic [N-1:0] hs;
    bit keep;
    s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tlast = '0; m_axis_tready = 0;
    forever begin
      @(negedge iclk);
      hs = s_axis_tvalid & s_axis_tready;
      @(posedge iclk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (hs[c] && chq[c].size() != 0) void'(chq[c].pop_front());
        if (chq[c].size() == 0) s_axis_tvalid[c] = 0;
        else begin
          keep = s_axis_tvalid[c] && !hs[c];
          s_axis_tvalid[c] = keep || chq[c][0].first || ($urandom_range(0, 2) != 0);
          s_axis_tdata[c*DW +: DW] = chq[c][0].data;
          s_axis_tlast[c] = chq[c][0].last;
        end
      end
      cyc++;
      m_axis_tready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
    end
  end
  initial begin
    bit stall_prev = 0;
    logic [7:0] prev_data = '0;
    int idle_cnt = 0;
    exp_t e;
    forever begin
      @(negedge iclk);
      if (!mon_en) stall_prev = 0;
      else begin
        if (m_axis_tvalid && stall_prev) chk("stable_tdata", m_axis_tdata, prev_data);
        if (ogrant[2]) g2++;
        if (m_axis_tvalid && m_axis_tready) begin
          if (exq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_byte actual=%0h required=none", m_axis_tdata);
          end else begin
            e = exq.pop_front();
            chk(e.hdr ? "hdr_data" : "pkt_data", m_axis_tdata, e.data);
            chk("grant", ogrant, 32'(1) << e.ch);
            chk("s_tready", s_axis_tready, e.hdr ? 0 : 32'(1) << e.ch);
            if (e.idle >= 0) chk("idle_gap", idle_cnt, e.idle);
          end
          idle_cnt = 0;
        end else if (!m_axis_tvalid) idle_cnt++;
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_data = m_axis_tdata;
      end
    end
  end
  initial begin
    int n, t;
    irst = 1; iena = '0; igap = '0;
    repeat (3) @(negedge iclk);
    chk("rst_grant", ogrant, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_busy", obusy, 0);
    chk("rst_sready", s_axis_tready, 0);
    irst = 0; mon_en = 1;
    iena = '1; igap = 0; mode = 0;
    push_beat(2, 8'h11, 0, 1); push_beat(2, 8'h22, 0, 0); push_beat(2, 8'h33, 1, 0);
    model(); wait_done();
    for (int c = 0; c < N; c++) add_pkt(c, 2);
    for (int c = 0; c < N; c++) add_pkt(c, 2);
    model(); wait_done();
    mode = 2;
    for (int c = 0; c < N; c++) add_pkt(c, 3);
    model(); wait_done();
    mode = 0; igap = 5;
    add_pkt(1, 1); add_pkt(1, 1);
    model(); wait_done();
    igap = 1; iena = 4'b1011; g2 = 0;
    for (int c = 0; c < N; c++) begin add_pkt(c, 2); add_pkt(c, 1); end
    model(); wait_done();
    chk("masked_ch2_grants", g2, 0);
    iena = '1; igap = 0;
    add_pkt(1, 4);
    model();
    n = 0;
    for (t = 0; t < 200 && n == 0; t++) begin
      @(negedge iclk);
      if (s_axis_tvalid[1] && s_axis_tready[1]) n++;
    end
    chk("ena_clear_seen", n, 1);
    iena[1] = 0;
    wait_done();
    iena = '1;
    mon_en = 0;
    add_pkt(3, 4);
    n = 0;
    for (t = 0; t < 200 && n < 2; t++) begin
      @(negedge iclk);
      if (s_axis_tvalid[3] && s_axis_tready[3]) n++;
    end
    chk("rst_mid_seen", n, 2);
    irst = 1;
    for (int c = 0; c < N; c++) chq[c].delete();
    @(negedge iclk);
    irst = 0;
    chk("midrst_grant", ogrant, 0);
    chk("midrst_mvalid", m_axis_tvalid, 0);
    chk("midrst_busy", obusy, 0);
    repeat (2) @(negedge iclk);
    mptr = N - 1; mon_en = 1;
    for (int c = N - 1; c >= 0; c--) add_pkt(c, 2);
    model(); wait_done();
    for (int r = 0; r < 20; r++) begin
      mode = $urandom_range(0, 2);
      igap = 16'($urandom_range(0, 3));
      iena = N'($urandom_range(1, (1 << N) - 1));
      for (int c = 0; c < N; c++) begin
        n = $urandom_range(0, 2);
        for (int p = 0; p < n; p++) add_pkt(c, $urandom_range(1, 4));
      end
      model(); wait_done();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sv_uart_tx_arb.md
Name: sv_uart_tx_arb

Overview:
- Packet-level round-robin arbiter that shares one UART transmitter between N_CH AXI-Stream byte sources.
- Optionally prefixes each packet with a channel-ID header byte.
- Enforces a programmable idle gap between packets.
- Sits between the per-channel producers (register/telemetry/debug streams) and the UART TX's s_axis slave port; m_axis_* connects directly to it.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- DATA_WIDTH, 8, byte width; must match the UART TX DATA_WIDTH.
- HDR_EN, 1, 1 = send header byte before each packet; 0 = no header.
- HDR_BASE, 8'hA0, header value = HDR_BASE + channel index, truncated to DATA_WIDTH.

Ports:
- iclk  in  1  clock
- irst  in  1  reset; synchronous, active-high
- s_axis_tdata  in  N_CH*DATA_WIDTH  channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  N_CH  per-channel valid
- s_axis_tlast  in  N_CH  per-channel end of packet
- s_axis_tready  out  N_CH  per-channel ready
- m_axis_tdata  out  DATA_WIDTH  byte to UART TX
- m_axis_tvalid  out  1  valid to UART TX
- m_axis_tready  in  1  ready from UART TX
- iena  in  N_CH  per-channel arbitration enable
- igap  in  16  idle cycles inserted after each packet's last beat
- ogrant  out  N_CH  one-hot current owner; 0 when none
- obusy  out  1  high in any state other than ST_IDLE

Behaviour:
- Reset: irst is synchronous and active-high; iclk is the clock. Reset values:
  - state = ST_IDLE
  - ogrant = 0, obusy = 0
  - m_axis_tvalid = 0, s_axis_tready = 0
  - gap counter = 0
  - RR pointer = N_CH-1, so channel 0 has first priority
- Reset mid-packet: the packet is abandoned immediately and the next cycle is ST_IDLE. No partial header and no tlast is emitted.
- Request: req[i] = s_axis_tvalid[i] & iena[i].
- ST_IDLE:
  - If any req, select the first requesting index searching from ptr+1 upward, wrapping modulo N_CH.
  - Register grant (ogrant one-hot) and ptr <= selected index.
  - Go to ST_HDR if HDR_EN, else ST_DATA.
  - Arbitration latency: 1 cycle from tvalid to ogrant.
  - No req: stay.
- ST_HDR:
  - m_axis_tvalid = 1; m_axis_tdata = HDR_BASE + idx.
  - All s_axis_tready = 0.
  - When m_axis_tready = 1: go to ST_DATA.
- ST_DATA:
  - m_axis_tdata and m_axis_tvalid are combinational passthrough of the granted channel.
  - s_axis_tready[idx] = m_axis_tready; all other s_axis_tready bits = 0.
  - Beat = s_axis_tvalid[idx] & m_axis_tready.
  - Beat with tlast[idx] = 1: if igap == 0 go to ST_IDLE, else load counter = igap and go to ST_GAP.
  - Clearing iena[idx] mid-packet does NOT abort; the packet runs to tlast.
  - Bubbles (tvalid low) hold the grant indefinitely.
- ST_GAP:
  - m_axis_tvalid = 0, all s_axis_tready = 0, ogrant = 0.
  - Counter decrements each cycle; at 1 go to ST_IDLE, giving exactly igap idle cycles.
  - igap is sampled only on entry to ST_GAP.
- ogrant: holds the one-hot grant through ST_HDR and ST_DATA; 0 in ST_IDLE and ST_GAP.
- Fairness: a channel that just finished has the lowest priority next round. With all channels requesting continuously the grant order is 0,1,2,…,N_CH-1,0.
- Single requester: repeatedly re-granted, with only the ST_IDLE cycle (plus gap) between packets.
- No combinational path from m_axis_tready to m_axis_tvalid. AXIS rules hold: m_axis_tdata is stable while tvalid is high and tready is low, provided the source complies.
- Unused state encoding: go to ST_IDLE.

Test Plan:
- Single packet, HDR_EN=1, ch2 sends {0x11, 0x22, 0x33 (tlast)}, m_axis_tready=1, igap=0 -> m_axis carries 0xA2, 0x11, 0x22, 0x33; ogrant=4'b0100 for 4 cycles; s_axis_tready[2] high only in the 3 data cycles; back to ST_IDLE.
- All 4 channels hold 2-byte packets after reset -> grant order 0,1,2,3,0; each packet is contiguous with no interleaving of bytes from another channel.
- Backpressure: m_axis_tready toggles 1,0,0,1,… -> each byte is transferred only on a tready=1 cycle; tdata is stable while stalled; no byte is lost or duplicated; header is held until accepted.
- Gap: igap=5, two back-to-back single-byte packets on ch1 -> exactly 5 cycles with m_axis_tvalid=0 after the first tlast, plus the 1 arbitration cycle, before the second header.
- Enable masking: iena=4'b1011 with all channels requesting -> ch2 is never granted. Clearing iena[1] mid-packet on ch1 -> that packet still completes through tlast.
- Reset mid-packet: assert irst for 1 cycle during byte 2 of a ch3 packet -> next cycle ogrant=0, m_axis_tvalid=0, obusy=0; the next arbitration grants ch0 first.
